// File: rtl/afifo_wm_if.sv
`default_nettype none
// ============================================================================
//  Module      : afifo_wm_if
//  Description : Write-side and read-side signal bundle of the afifo_wm
//                asynchronous FIFO. The FIFO takes the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface afifo_wm_if #(
    parameter int DW = 128,
    parameter int AW = 4
);
    // Write domain (WClk)
    logic          we;
    logic [DW-1:0] d;
    logic          wfull;
    logic          wafull;
    logic [AW:0]   wafull_th;
    logic [AW:0]   wnum;
    logic          wovf;
    logic          wovf_clr;
    // Read domain (RClk)
    logic          re;
    logic [DW-1:0] q;
    logic          rempty;
    logic          raempty;
    logic [AW:0]   raempty_th;
    logic [AW:0]   rnum;
    logic          rudf;
    logic          rudf_clr;

    modport master (
        output we, d, wafull_th, wovf_clr, re, raempty_th, rudf_clr,
        input  wfull, wafull, wnum, wovf, q, rempty, raempty, rnum, rudf
    );

    modport slave (
        input  we, d, wafull_th, wovf_clr, re, raempty_th, rudf_clr,
        output wfull, wafull, wnum, wovf, q, rempty, raempty, rnum, rudf
    );
endinterface
`default_nettype wire

// File: rtl/afifo_wm.sv
`default_nettype none
// ============================================================================
//  Module      : afifo_wm
//  Description : Dual-clock FIFO with Gray-coded pointers, watermark flags,
//                occupancy counts and sticky overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module afifo_wm #(
    parameter int DW = 128,
    parameter int AW = 4,
    parameter int SS = 2
) (
    input  wire        WClk,
    input  wire        RClk,
    input  wire        rstn,
    afifo_wm_if.slave  bus
);
    localparam int          c_DEPTH     = 1 << AW;
    // Full when the write pointer leads the synced read pointer by one lap:
    // in Gray code that is the two MSBs inverted, the rest equal.
    localparam logic [AW:0] c_FULL_MASK = ~({(AW+1){1'b1}} >> 2);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Per-domain reset: asserts asynchronously, releases on the local clock.
    logic [1:0] wrst_q;
    logic [1:0] rrst_q;
    logic       wrst_n;
    logic       rrst_n;

    always_ff @(posedge WClk or negedge rstn) begin
        if (!rstn) wrst_q <= 2'b00;
        else       wrst_q <= {wrst_q[0], 1'b1};
    end

    always_ff @(posedge RClk or negedge rstn) begin
        if (!rstn) rrst_q <= 2'b00;
        else       rrst_q <= {rrst_q[0], 1'b1};
    end

    assign wrst_n = wrst_q[1];
    assign rrst_n = rrst_q[1];

    logic [DW-1:0] mem_q [c_DEPTH];

    logic [AW:0] wbin_q, wgray_q, wbin_d, wgray_d, w_rbin;
    logic [AW:0] rbin_q, rgray_q, rbin_d, rgray_d, r_wbin;
    logic [AW:0] rsync_q [SS];
    logic [AW:0] wsync_q [SS];
    logic        wfull_q, wafull_q, wovf_q, wfull_d, wafull_d, wovf_d, winc;
    logic        rempty_q, raempty_q, rudf_q, rempty_d, raempty_d, rudf_d, rinc;

    // ---------------- write domain ----------------
    always_comb begin
        winc     = bus.we & ~wfull_q;
        wbin_d   = wbin_q + (AW+1)'(winc);
        wgray_d  = bin2gray(wbin_d);
        w_rbin   = gray2bin(rsync_q[SS-1]);
        wfull_d  = (wgray_d == (rsync_q[SS-1] ^ c_FULL_MASK));
        wafull_d = ((wbin_d - w_rbin) >= bus.wafull_th);
        wovf_d   = (bus.we & wfull_q) | (wovf_q & ~bus.wovf_clr);
    end

    always_ff @(posedge WClk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wfull_q  <= 1'b1;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
            for (int i = 0; i < SS; i++) rsync_q[i] <= '0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            wfull_q    <= wfull_d;
            wafull_q   <= wafull_d;
            wovf_q     <= wovf_d;
            rsync_q[0] <= rgray_q;
            for (int i = 1; i < SS; i++) rsync_q[i] <= rsync_q[i-1];
        end
    end

    always_ff @(posedge WClk) begin
        if (winc) mem_q[wbin_q[AW-1:0]] <= bus.d;
    end

    assign bus.wfull  = wfull_q;
    assign bus.wafull = wafull_q;
    assign bus.wovf   = wovf_q;
    assign bus.wnum   = wbin_q - w_rbin;

    // ---------------- read domain ----------------
    always_comb begin
        rinc      = bus.re & ~rempty_q;
        rbin_d    = rbin_q + (AW+1)'(rinc);
        rgray_d   = bin2gray(rbin_d);
        r_wbin    = gray2bin(wsync_q[SS-1]);
        rempty_d  = (rgray_d == wsync_q[SS-1]);
        raempty_d = ((r_wbin - rbin_d) <= bus.raempty_th);
        rudf_d    = (bus.re & rempty_q) | (rudf_q & ~bus.rudf_clr);
    end

    always_ff @(posedge RClk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q    <= '0;
            rgray_q   <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= 1'b1;
            rudf_q    <= 1'b0;
            for (int i = 0; i < SS; i++) wsync_q[i] <= '0;
        end else begin
            rbin_q     <= rbin_d;
            rgray_q    <= rgray_d;
            rempty_q   <= rempty_d;
            raempty_q  <= raempty_d;
            rudf_q     <= rudf_d;
            wsync_q[0] <= wgray_q;
            for (int i = 1; i < SS; i++) wsync_q[i] <= wsync_q[i-1];
        end
    end

    assign bus.q       = mem_q[rbin_q[AW-1:0]];
    assign bus.rempty  = rempty_q;
    assign bus.raempty = raempty_q;
    assign bus.rudf    = rudf_q;
    assign bus.rnum    = r_wbin - rbin_q;

endmodule
`default_nettype wire

// File: doc/afifo_wm.md
AFIFO_WM -- requirements
Module: afifo_wm

Interface
Parameters:
REQ-001 DW, 128, data width in bits, >=1.
REQ-002 AW, 4, log2(depth); depth DEPTH = 2**AW; AW >= 1.
REQ-003 SS, 2, pointer synchronizer stages per direction; legal 2..4.
Ports:
REQ-004 WClk  in  1  write clock.
REQ-005 RClk  in  1  read clock; asynchronous to WClk.
REQ-006 rstn  in  1  reset, asynchronous, active-low; one pin resets both domains.
REQ-007 we  in  1  write request (WClk).
REQ-008 d  in  DW  write data (WClk).
REQ-009 wfull  out  1  full flag, registered (WClk).
REQ-010 wafull  out  1  almost-full flag, registered (WClk).
REQ-011 wafull_th  in  AW+1  almost-full threshold; quasi-static.
REQ-012 wnum  out  AW+1  write-side occupancy (WClk).
REQ-013 wovf  out  1  sticky overflow flag (WClk).
REQ-014 wovf_clr  in  1  clears wovf (WClk).
REQ-015 re  in  1  read request (RClk).
REQ-016 q  out  DW  read data, show-ahead: head word is valid whenever rempty=0.
REQ-017 rempty  out  1  empty flag, registered (RClk).
REQ-018 raempty  out  1  almost-empty flag, registered (RClk).
REQ-019 raempty_th  in  AW+1  almost-empty threshold; quasi-static.
REQ-020 rnum  out  AW+1  read-side occupancy (RClk).
REQ-021 rudf  out  1  sticky underflow flag (RClk).
REQ-022 rudf_clr  in  1  clears rudf (RClk).

Function
REQ-023 Storage SHALL be DEPTH x DW; written on the WClk edge; read combinationally at the read address (q = mem[raddr]).
REQ-024 Write and read pointers SHALL be (AW+1)-bit Gray; the address is the binary pointer's low AW bits.
REQ-025 Each pointer SHALL cross to the other domain through SS flops in that domain, reset to 0.
REQ-026 Accepted write: we & ~wfull; memory written and wptr += 1 on the same WClk edge.
REQ-027 Accepted read: re & ~rempty; rptr += 1 on the RClk edge; q then shows the next word combinationally.
REQ-028 Blocked write (we & wfull): no memory or pointer change; wovf SHALL be set on that edge.
REQ-029 Blocked read (re & rempty): no pointer change; rudf SHALL be set on that edge.
REQ-030 Sticky clear: wovf_clr/rudf_clr clear the flag next edge; if set and clear occur together, set SHALL win.
REQ-031 wfull is registered from the next-state compare: wptr_nx == sync(rptr) with the 2 MSBs inverted.
REQ-032 rempty is registered from the next-state compare: rptr_nx == sync(wptr).
REQ-033 wnum = bin(wptr) - bin(sync rptr), modulo 2**(AW+1); range 0..DEPTH.
REQ-034 rnum = bin(sync wptr) - bin(rptr), modulo 2**(AW+1); range 0..DEPTH.
REQ-035 wafull is registered: (wptr_nx - sync rptr) >= wafull_th.
REQ-036 raempty is registered: (sync wptr - rptr_nx) <= raempty_th.
REQ-037 Pointers SHALL wrap past 2**(AW+1)-1 to 0 with no flag glitch; full and empty are distinguished by the MSB.
REQ-038 Latency: a write on WClk edge k SHALL deassert rempty within SS+1 RClk edges after k; a read SHALL deassert wfull within SS+1 WClk edges.
REQ-039 Flags are pessimistic only: wfull/wnum may overstate occupancy and rempty/rnum may understate it during sync delay; never the reverse.

Reset
REQ-040 rstn low SHALL asynchronously reset both domains.
REQ-041 Deassertion SHALL be synchronized separately into each domain with a 2-flop synchronizer whose D input is tied high.
REQ-042 Reset values: pointers 0, syncs 0, wfull=1 (writes denied during reset), wafull=0, wnum=0, wovf=0, rempty=1, raempty=1, rnum=0, rudf=0.
REQ-043 After release, wfull SHALL drop on the 1st WClk edge in which the write domain is out of reset.
REQ-044 Reset mid-operation discards all contents; memory contents need not be cleared.

Verification
REQ-045 AW=2, SS=2, WClk 10ns, RClk 13ns: write 0x11..0x44 -> wfull=1, wnum=4; 5th write -> wovf=1, memory unchanged; read 4 -> q=0x11,0x22,0x33,0x44, then rempty=1.
REQ-046 Empty FIFO, one write of 0xA5 -> rempty falls within 3 RClk edges, q=0xA5, rnum=1.
REQ-047 wafull_th=3, raempty_th=1: write 3 -> wafull=1 on 3rd write edge; read until rnum=1 -> raempty=1.
REQ-048 Read with rempty=1 -> rudf=1, rptr unchanged; assert rudf_clr with a further blocked read in the same cycle -> rudf stays 1.
REQ-049 Stream 1000 random words, with WClk/RClk ratios 1:3 and 3:1 -> data order preserved, no loss; pointers wrap >=100 times.
REQ-050 Assert rstn mid-stream for 1 RClk period -> all outputs take REQ-042 values asynchronously; the FIFO works correctly after release.
